// File: rtl/control_mc.sv
// control_mc: multi-cycle RV32I control sequencer owning PC and IR.
// Fetches over a req/ack instruction bus, drives a byte-enable data bus, and traps on faults.
module control_mc #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [3:0]  dmem_be_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wr_data_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rd_data_in,
    output logic [4:0]  reg_rd_idx1_out,
    output logic [4:0]  reg_rd_idx2_out,
    input  logic [31:0] reg_rd_data1_in,
    input  logic [31:0] reg_rd_data2_in,
    output logic        reg_wr_en_out,
    output logic [4:0]  reg_wr_idx_out,
    output logic [31:0] reg_wr_data_out,
    output logic [9:0]  alu_cid_out,
    output logic [31:0] alu_arg1_out,
    output logic [31:0] alu_arg2_out,
    input  logic [31:0] alu_arg_in,
    output logic [31:0] pc_out,
    output logic        retire_out,
    output logic        trap_out,
    output logic [1:0]  trap_cause_out,
    output logic [31:0] trap_pc_out
);
    localparam int unsigned   CW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic          TO_EN   = (MEM_TIMEOUT != 0);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {StBoot, StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;

    state_e        r_state, w_state_d;
    logic [31:0]   r_pc, r_ir, r_a, r_b, r_r, r_next_pc, r_trap_pc;
    logic [1:0]    r_trap_cause, w_cause;
    logic [CW-1:0] r_cnt;
    logic          w_trap, w_timeout;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_is_store, w_is_ls, w_is_shift, w_legal, w_taken, w_jump, w_writes_rd;
    logic [31:0] w_jalr_sum, w_target, w_ls_addr, w_exec_res, w_lane, w_load_data;
    logic        w_ls_misal;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_rd     = r_ir[11:7];
    assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s  = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b  = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u  = {r_ir[31:12], 12'b0};
    assign w_imm_j  = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    assign w_is_store  = (w_opcode == OPC_STORE);
    assign w_is_ls     = w_is_store || (w_opcode == OPC_LOAD);
    assign w_is_shift  = (w_opcode == OPC_OPIMM) && (w_funct3[1:0] == 2'b01);
    assign w_writes_rd = (w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) ||
                         (w_opcode == OPC_JAL) || (w_opcode == OPC_JALR) ||
                         (w_opcode == OPC_LOAD) || (w_opcode == OPC_OPIMM) ||
                         (w_opcode == OPC_OP);
    assign w_jalr_sum  = r_a + w_imm_i;
    assign w_ls_addr   = r_a + (w_is_store ? w_imm_s : w_imm_i);
    assign w_ls_misal  = ((w_funct3[1:0] == 2'b01) && w_ls_addr[0]) ||
                         ((w_funct3[1:0] == 2'b10) && (w_ls_addr[1:0] != 2'b00));
    assign w_timeout   = TO_EN && (r_cnt == TO_LAST);
    assign w_lane      = dmem_rd_data_in >> {r_r[1:0], 3'b000};

    always_comb begin
        case (w_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_OPIMM, OPC_OP, OPC_FENCE: w_legal = 1'b1;
            OPC_BRANCH: w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            OPC_LOAD:   w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) &&
                                  (w_funct3 != 3'b111);
            OPC_STORE:  w_legal = (w_funct3 < 3'b011);
            default:    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_taken = (r_a == r_b);
            3'b001:  w_taken = (r_a != r_b);
            3'b100:  w_taken = ($signed(r_a) < $signed(r_b));
            3'b101:  w_taken = ($signed(r_a) >= $signed(r_b));
            3'b110:  w_taken = (r_a < r_b);
            3'b111:  w_taken = (r_a >= r_b);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_target = r_pc + 32'd4;
        w_jump   = 1'b0;
        if (w_opcode == OPC_JAL) begin
            w_target = r_pc + w_imm_j;
            w_jump   = 1'b1;
        end else if (w_opcode == OPC_JALR) begin
            w_target = {w_jalr_sum[31:1], 1'b0};
            w_jump   = 1'b1;
        end else if ((w_opcode == OPC_BRANCH) && w_taken) begin
            w_target = r_pc + w_imm_b;
            w_jump   = 1'b1;
        end
    end

    always_comb begin
        case (w_opcode)
            OPC_LUI:             w_exec_res = w_imm_u;
            OPC_AUIPC:           w_exec_res = r_pc + w_imm_u;
            OPC_JAL, OPC_JALR:   w_exec_res = r_pc + 32'd4;
            OPC_LOAD, OPC_STORE: w_exec_res = w_ls_addr;
            default:             w_exec_res = alu_arg_in;
        endcase
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_data = {24'b0, w_lane[7:0]};
            3'b101:  w_load_data = {16'b0, w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= StBoot;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d        = r_state;
        w_trap           = 1'b0;
        w_cause          = 2'd0;
        imem_req_out     = 1'b0;
        dmem_req_out     = 1'b0;
        dmem_we_out      = 1'b0;
        dmem_be_out      = 4'b0000;
        dmem_addr_out    = 32'b0;
        dmem_wr_data_out = 32'b0;
        reg_wr_en_out    = 1'b0;
        reg_wr_idx_out   = 5'b0;
        reg_wr_data_out  = 32'b0;
        alu_cid_out      = 10'b0;
        alu_arg1_out     = 32'b0;
        alu_arg2_out     = 32'b0;
        retire_out       = 1'b0;
        trap_out         = 1'b0;
        case (r_state)
            StBoot: w_state_d = StFetch;
            StFetch: begin
                if (r_pc[1:0] != 2'b00) begin
                    w_trap  = 1'b1;
                    w_cause = 2'd1;
                end else begin
                    imem_req_out = 1'b1;
                    if (imem_ack_in) w_state_d = StDecode;
                    else if (w_timeout) begin
                        w_trap  = 1'b1;
                        w_cause = 2'd2;
                    end
                end
            end
            StDecode: begin
                if (w_legal) w_state_d = StExec;
                else w_trap = 1'b1;
            end
            StExec: begin
                alu_arg1_out = r_a;
                alu_arg2_out = r_b;
                if (w_opcode == OPC_OP) begin
                    alu_cid_out = {w_funct3, r_ir[31:25]};
                end else if (w_opcode == OPC_OPIMM) begin
                    alu_cid_out  = w_is_shift ? {w_funct3, r_ir[31:25]} : {w_funct3, 7'b0};
                    alu_arg2_out = w_is_shift ? {27'b0, w_imm_i[4:0]} : w_imm_i;
                end
                if (w_jump && w_target[1]) begin
                    w_trap  = 1'b1;
                    w_cause = 2'd1;
                end else if (w_is_ls && w_ls_misal) begin
                    w_trap  = 1'b1;
                    w_cause = 2'd3;
                end else begin
                    w_state_d = w_is_ls ? StMem : StWb;
                end
            end
            StMem: begin
                dmem_req_out  = 1'b1;
                dmem_addr_out = {r_r[31:2], 2'b00};
                dmem_be_out   = 4'b1111;
                if (w_is_store) begin
                    dmem_we_out = 1'b1;
                    case (w_funct3[1:0])
                        2'b00: begin
                            dmem_be_out      = 4'b0001 << r_r[1:0];
                            dmem_wr_data_out = {4{r_b[7:0]}};
                        end
                        2'b01: begin
                            dmem_be_out      = 4'b0011 << r_r[1:0];
                            dmem_wr_data_out = {2{r_b[15:0]}};
                        end
                        default: dmem_wr_data_out = r_b;
                    endcase
                end
                if (dmem_ack_in) w_state_d = StWb;
                else if (w_timeout) begin
                    w_trap  = 1'b1;
                    w_cause = 2'd2;
                end
            end
            StWb: begin
                reg_wr_en_out   = w_writes_rd && (w_rd != 5'd0);
                reg_wr_idx_out  = reg_wr_en_out ? w_rd : 5'd0;
                reg_wr_data_out = reg_wr_en_out ? r_r : 32'b0;
                retire_out      = 1'b1;
                w_state_d       = StFetch;
            end
            StTrap: begin
                trap_out  = 1'b1;
                w_state_d = StFetch;
            end
            default: w_state_d = StBoot;
        endcase
        if (w_trap) w_state_d = StTrap;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pc         <= RESET_VECTOR;
            r_ir         <= 32'b0;
            r_a          <= 32'b0;
            r_b          <= 32'b0;
            r_r          <= 32'b0;
            r_next_pc    <= 32'b0;
            r_cnt        <= '0;
            r_trap_cause <= 2'd0;
            r_trap_pc    <= 32'b0;
        end else begin
            // Counter runs only while waiting in FETCH/MEM; any state change clears it.
            if ((r_state == w_state_d) && ((r_state == StFetch) || (r_state == StMem))) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == StFetch) && (w_state_d == StDecode)) r_ir <= imem_data_in;
            if (r_state == StDecode) begin
                r_a <= reg_rd_data1_in;
                r_b <= reg_rd_data2_in;
            end
            if (r_state == StExec) begin
                r_r       <= w_exec_res;
                r_next_pc <= w_target;
            end
            if ((r_state == StMem) && dmem_ack_in && !w_is_store) r_r <= w_load_data;
            if (r_state == StWb) r_pc <= r_next_pc;
            if (r_state == StTrap) r_pc <= TRAP_VECTOR;
            if (w_trap) begin
                r_trap_cause <= w_cause;
                r_trap_pc    <= r_pc;
            end
        end
    end

    assign reg_rd_idx1_out = r_ir[19:15];
    assign reg_rd_idx2_out = r_ir[24:20];
    assign pc_out          = r_pc;
    assign imem_addr_out   = r_pc;
    assign trap_cause_out  = r_trap_cause;
    assign trap_pc_out     = r_trap_pc;
endmodule

// File: tb/tb_control_mc.sv
// Directed bench for control_mc: small imem/dmem/regfile/ALU models around the sequencer.
module tb_control_mc;
    logic        clk = 1'b0;
    logic        nrst;
    logic        imem_req_out, imem_ack_in;
    logic [31:0] imem_addr_out, imem_data_in;
    logic        dmem_req_out, dmem_we_out, dmem_ack_in;
    logic [3:0]  dmem_be_out;
    logic [31:0] dmem_addr_out, dmem_wr_data_out, dmem_rd_data_in;
    logic [4:0]  reg_rd_idx1_out, reg_rd_idx2_out, reg_wr_idx_out;
    logic [31:0] reg_rd_data1_in, reg_rd_data2_in, reg_wr_data_out;
    logic        reg_wr_en_out;
    logic [9:0]  alu_cid_out;
    logic [31:0] alu_arg1_out, alu_arg2_out, alu_arg_in;
    logic [31:0] pc_out, trap_pc_out;
    logic        retire_out, trap_out;
    logic [1:0]  trap_cause_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog [0:255];
    logic [31:0] rf [0:31];
    int          imem_waits = 0;
    int          dmem_waits = 0;
    int          i_wcnt, d_wcnt;
    int          wr_count = 0;
    logic        stray_iack = 1'b0;
    logic [31:0] dmem_rdata = 32'b0;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = 5'd0;
    logic [31:0] pl_val = 32'b0;

    always #5 clk = ~clk;

    control_mc #(
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_ack_in     (imem_ack_in),
        .imem_data_in    (imem_data_in),
        .dmem_req_out    (dmem_req_out),
        .dmem_we_out     (dmem_we_out),
        .dmem_be_out     (dmem_be_out),
        .dmem_addr_out   (dmem_addr_out),
        .dmem_wr_data_out(dmem_wr_data_out),
        .dmem_ack_in     (dmem_ack_in),
        .dmem_rd_data_in (dmem_rd_data_in),
        .reg_rd_idx1_out (reg_rd_idx1_out),
        .reg_rd_idx2_out (reg_rd_idx2_out),
        .reg_rd_data1_in (reg_rd_data1_in),
        .reg_rd_data2_in (reg_rd_data2_in),
        .reg_wr_en_out   (reg_wr_en_out),
        .reg_wr_idx_out  (reg_wr_idx_out),
        .reg_wr_data_out (reg_wr_data_out),
        .alu_cid_out     (alu_cid_out),
        .alu_arg1_out    (alu_arg1_out),
        .alu_arg2_out    (alu_arg2_out),
        .alu_arg_in      (alu_arg_in),
        .pc_out          (pc_out),
        .retire_out      (retire_out),
        .trap_out        (trap_out),
        .trap_cause_out  (trap_cause_out),
        .trap_pc_out     (trap_pc_out)
    );

    // Bus models: ack once the request has waited the configured number of cycles.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            i_wcnt <= 0;
            d_wcnt <= 0;
        end else begin
            i_wcnt <= (imem_req_out && !imem_ack_in) ? i_wcnt + 1 : 0;
            d_wcnt <= (dmem_req_out && !dmem_ack_in) ? d_wcnt + 1 : 0;
        end
    end
    assign imem_ack_in     = (imem_req_out && (i_wcnt >= imem_waits)) || stray_iack;
    assign dmem_ack_in     = dmem_req_out && (d_wcnt >= dmem_waits);
    assign imem_data_in    = prog[imem_addr_out[9:2]];
    assign dmem_rd_data_in = dmem_rdata;

    assign reg_rd_data1_in = (reg_rd_idx1_out == 5'd0) ? 32'b0 : rf[reg_rd_idx1_out];
    assign reg_rd_data2_in = (reg_rd_idx2_out == 5'd0) ? 32'b0 : rf[reg_rd_idx2_out];
    always @(posedge clk) begin
        if (pl_en) begin
            rf[pl_idx] <= pl_val;
        end else if (reg_wr_en_out) begin
            rf[reg_wr_idx_out] <= reg_wr_data_out;
            wr_count <= wr_count + 1;
        end
    end

    always_comb begin
        if ((alu_cid_out[9:7] == 3'b000) && alu_cid_out[5]) alu_arg_in = alu_arg1_out - alu_arg2_out;
        else alu_arg_in = alu_arg1_out + alu_arg2_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0000_0013;
    endtask

    // Holds reset while preloading x1/x2, then releases on a falling edge (DUT in BOOT).
    task automatic start(input logic [31:0] x1, input logic [31:0] x2);
        nrst   = 1'b0;
        pl_en  = 1'b1;
        pl_idx = 5'd1;
        pl_val = x1;
        tick();
        pl_idx = 5'd2;
        pl_val = x2;
        tick();
        pl_en = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick();
        tick();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc_out); end
        checks++; if (imem_addr_out !== 32'h0) begin errors++; $display("FAIL rst_iaddr got %h want 0", imem_addr_out); end
        checks++; if ({imem_req_out, dmem_req_out, reg_wr_en_out, retire_out, trap_out} !== 5'b0) begin
            errors++; $display("FAIL rst_strobes got %b want 00000",
                {imem_req_out, dmem_req_out, reg_wr_en_out, retire_out, trap_out});
        end
        checks++; if ({trap_cause_out, trap_pc_out} !== 34'h0) begin
            errors++; $display("FAIL rst_trapregs got %h/%h want 0/0", trap_cause_out, trap_pc_out);
        end
        checks++; if ({alu_cid_out, reg_rd_idx1_out} !== 15'h0) begin
            errors++; $display("FAIL rst_ir_outs got %h/%h want 0/0", alu_cid_out, reg_rd_idx1_out);
        end
    endtask

    task automatic test_alu_addi();
        clear_prog();
        prog[0] = 32'h0050_0093;
        start(32'h0, 32'h0);
        checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL addi_boot_req got %b want 0", imem_req_out); end
        tick();
        checks++; if ({imem_req_out, imem_addr_out} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL addi_fetch got %b/%h want 1/0", imem_req_out, imem_addr_out);
        end
        tick();
        tick();
        checks++; if (reg_wr_en_out !== 1'b0) begin errors++; $display("FAIL addi_early_wr got %b want 0", reg_wr_en_out); end
        tick();
        checks++; if ({reg_wr_en_out, reg_wr_idx_out, reg_wr_data_out, retire_out} !== {1'b1, 5'd1, 32'd5, 1'b1}) begin
            errors++; $display("FAIL addi_wb got en=%b idx=%0d data=%h ret=%b want 1/1/5/1",
                reg_wr_en_out, reg_wr_idx_out, reg_wr_data_out, retire_out);
        end
        tick();
        checks++; if ({imem_req_out, imem_addr_out, retire_out} !== {1'b1, 32'h4, 1'b0}) begin
            errors++; $display("FAIL addi_next got req=%b addr=%h ret=%b want 1/4/0",
                imem_req_out, imem_addr_out, retire_out);
        end
    endtask

    task automatic test_store_sb();
        int          req_cycles;
        int          wc0;
        logic        got;
        logic        retired;
        logic [31:0] a, d;
        logic [3:0]  be;
        logic        we;
        clear_prog();
        prog[0] = 32'h0020_81A3;
        dmem_waits = 2;
        start(32'h0000_1000, 32'h0000_00AB);
        wc0 = wr_count;
        req_cycles = 0; got = 1'b0; retired = 1'b0;
        a = 32'h0; d = 32'h0; be = 4'h0; we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dmem_req_out) begin
                req_cycles++;
                if (!got) begin
                    got = 1'b1; a = dmem_addr_out; d = dmem_wr_data_out; be = dmem_be_out; we = dmem_we_out;
                end
            end
            if (retire_out) begin
                retired = 1'b1;
                break;
            end
        end
        checks++; if (a !== 32'h1000) begin errors++; $display("FAIL sb_addr got %h want 00001000", a); end
        checks++; if (be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b want 1000", be); end
        checks++; if (d !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_data got %h want abababab", d); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL sb_we got %b want 1", we); end
        checks++; if (req_cycles != 3) begin errors++; $display("FAIL sb_req_cycles got %0d want 3", req_cycles); end
        checks++; if (retired !== 1'b1) begin errors++; $display("FAIL sb_retire got %b want 1", retired); end
        checks++; if (wr_count != wc0) begin errors++; $display("FAIL sb_regwrite got %0d writes want 0", wr_count - wc0); end
        dmem_waits = 0;
    endtask

    task automatic test_load_op();
        clear_prog();
        prog[0] = 32'h0020_9203;  // lh x4,2(x1)
        prog[1] = 32'h4020_82B3;  // sub x5,x1,x2
        dmem_rdata = 32'h8001_1234;
        start(32'h0000_1000, 32'h0000_00AB);
        tick(); tick(); tick(); tick();
        checks++; if ({dmem_req_out, dmem_we_out, dmem_be_out, dmem_addr_out} !== {1'b1, 1'b0, 4'hF, 32'h1000}) begin
            errors++; $display("FAIL lh_mem got req=%b we=%b be=%b addr=%h want 1/0/1111/00001000",
                dmem_req_out, dmem_we_out, dmem_be_out, dmem_addr_out);
        end
        tick();
        checks++; if ({reg_wr_en_out, reg_wr_idx_out, reg_wr_data_out} !== {1'b1, 5'd4, 32'hFFFF_8001}) begin
            errors++; $display("FAIL lh_wb got en=%b idx=%0d data=%h want 1/4/ffff8001",
                reg_wr_en_out, reg_wr_idx_out, reg_wr_data_out);
        end
        tick(); tick(); tick();
        checks++; if ({alu_cid_out, alu_arg1_out, alu_arg2_out} !== {10'h020, 32'h1000, 32'hAB}) begin
            errors++; $display("FAIL sub_exec got cid=%h a1=%h a2=%h want 020/00001000/000000ab",
                alu_cid_out, alu_arg1_out, alu_arg2_out);
        end
        tick();
        checks++; if ({reg_wr_en_out, reg_wr_idx_out, reg_wr_data_out} !== {1'b1, 5'd5, 32'h0F55}) begin
            errors++; $display("FAIL sub_wb got en=%b idx=%0d data=%h want 1/5/00000f55",
                reg_wr_en_out, reg_wr_idx_out, reg_wr_data_out);
        end
    endtask

    task automatic test_load_misaligned();
        logic found;
        logic saw_dreq;
        int   wc0;
        clear_prog();
        prog[0]  = 32'h0400_006F;  // jal x0,+0x40
        prog[16] = 32'h0020_A183;  // lw x3,2(x1)
        start(32'h0000_1000, 32'h0);
        wc0 = wr_count;
        found = 1'b0; saw_dreq = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dmem_req_out) saw_dreq = 1'b1;
            if (trap_out) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL lwmis_trap got no trap want trap"); end
        checks++; if ({trap_cause_out, trap_pc_out} !== {2'd3, 32'h40}) begin
            errors++; $display("FAIL lwmis_cause got %0d/%h want 3/00000040", trap_cause_out, trap_pc_out);
        end
        checks++; if (saw_dreq !== 1'b0) begin errors++; $display("FAIL lwmis_dreq got 1 want 0"); end
        checks++; if (wr_count != wc0) begin errors++; $display("FAIL lwmis_regwrite got %0d want 0", wr_count - wc0); end
        tick();
        checks++; if ({trap_out, imem_req_out, imem_addr_out} !== {1'b0, 1'b1, 32'h100}) begin
            errors++; $display("FAIL lwmis_vector got trap=%b req=%b addr=%h want 0/1/00000100",
                trap_out, imem_req_out, imem_addr_out);
        end
    endtask

    task automatic test_timeout();
        int   req_cycles;
        logic found;
        clear_prog();
        prog[64]  = 32'h0080_00EF;  // 0x100: jal x1,+8
        prog[66]  = 32'h0F80_006F;  // 0x108: jal x0,+0xF8
        prog[128] = 32'h0000_0363;  // 0x200: beq x0,x0,+6
        imem_waits = 1000;
        start(32'h0, 32'h0);
        req_cycles = 0; found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (imem_req_out) req_cycles++;
            if (trap_out) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL to_trap got no trap want trap"); end
        checks++; if (req_cycles != 8) begin errors++; $display("FAIL to_req_cycles got %0d want 8", req_cycles); end
        checks++; if ({trap_cause_out, trap_pc_out} !== {2'd2, 32'h0}) begin
            errors++; $display("FAIL to_cause got %0d/%h want 2/00000000", trap_cause_out, trap_pc_out);
        end
        imem_waits = 0;
        stray_iack = 1'b1;  // late ack while no request is outstanding
        tick();
        stray_iack = 1'b0;
        checks++; if ({imem_req_out, imem_addr_out, pc_out} !== {1'b1, 32'h100, 32'h100}) begin
            errors++; $display("FAIL to_refetch got req=%b addr=%h pc=%h want 1/00000100/00000100",
                imem_req_out, imem_addr_out, pc_out);
        end
    endtask

    // Continues from the TRAP_VECTOR fetch left by test_timeout.
    task automatic test_jump_branch();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (reg_wr_en_out) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if ({found, reg_wr_idx_out, reg_wr_data_out} !== {1'b1, 5'd1, 32'h104}) begin
            errors++; $display("FAIL jal_link got found=%b idx=%0d data=%h want 1/1/00000104",
                found, reg_wr_idx_out, reg_wr_data_out);
        end
        tick();
        checks++; if (imem_addr_out !== 32'h108) begin errors++; $display("FAIL jal_target got %h want 00000108", imem_addr_out); end
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (trap_out) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if ({found, trap_cause_out, trap_pc_out} !== {1'b1, 2'd1, 32'h200}) begin
            errors++; $display("FAIL beq_mis got found=%b cause=%0d pc=%h want 1/1/00000200",
                found, trap_cause_out, trap_pc_out);
        end
    endtask

    task automatic test_reset_mid_store();
        logic found;
        int   wc0;
        clear_prog();
        prog[0] = 32'h0020_81A3;
        dmem_waits = 1000;
        start(32'h0000_1000, 32'h0000_00AB);
        wc0 = wr_count;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dmem_req_out) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_req got no request want request"); end
        tick();
        tick();
        #2;
        nrst = 1'b0;
        #1;
        checks++; if ({dmem_req_out, imem_req_out, pc_out} !== {1'b0, 1'b0, 32'h0}) begin
            errors++; $display("FAIL rstmid_async got dreq=%b ireq=%b pc=%h want 0/0/00000000",
                dmem_req_out, imem_req_out, pc_out);
        end
        checks++; if (wr_count != wc0) begin errors++; $display("FAIL rstmid_regwrite got %0d want 0", wr_count - wc0); end
        dmem_waits = 0;
        @(negedge clk);
        nrst = 1'b1;
        tick();
        checks++; if ({imem_req_out, imem_addr_out} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL rstmid_refetch got req=%b addr=%h want 1/00000000", imem_req_out, imem_addr_out);
        end
    endtask

    initial begin
        nrst = 1'b0;
        clear_prog();
        test_reset();
        test_alu_addi();
        test_store_sb();
        test_load_op();
        test_load_misaligned();
        test_timeout();
        test_jump_branch();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
